// File: rtl/dmem_responder.sv
// Stalling data-memory responder: word RAM behind an IDLE/WAIT/RESP handshake.
// Optional misaligned-access error reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          DATA_W = 32;
  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT  = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, next_state;
  logic [3:0] cnt;

  logic              wr_p0;
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic          req;
  logic          access;
  logic          in_range;
  logic          misalign;
  logic [AW-1:0] idx;

  assign req      = req_read | req_write;
  assign access   = (state == S_WAIT) && (cnt == 4'd0);
  assign in_range = addr_p0 < LIMIT;
  assign idx      = addr_p0[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |addr_p0[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && req)
        cnt <= 4'(WAIT_STATES);
      else if (state == S_WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req) next_state = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Request capture: only the values latched here drive the access.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      wr_p0    <= req_write;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Access edge: RAM write or read-data update, leading into RESP.
  always_ff @(posedge clk) begin
    if (access && wr_p0 && in_range && !misalign && !reset)
      mem[idx] <= wdata_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      resp_rdata <= '0;
    else if (access && !wr_p0 && !misalign)
      resp_rdata <= in_range ? mem[idx] : '0;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_p0;

  // Set only by the access edge, so it is high exactly during RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_p0 <= 1'b0;
    else
      err_p0 <= access && misalign;
  end

  assign resp_err = err_p0;
`else
  assign resp_err = 1'b0;
`endif

  assign resp_ready = (state == S_RESP);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WS    = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata = '0;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_read(req_read),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction: model result computed up front, then the DUT is
  // followed cycle by cycle from acceptance until it is back in IDLE.
  // With hold set, a write to 0x20 stays on the inputs through RESP.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit hold);
    bit          mis;
    bit          inr;
    logic [31:0] prev;
    logic [31:0] nxt;
    mis  = ALIGN && (addr[1:0] != 2'b00);
    inr  = addr < 32'(DEPTH * 4);
    prev = model_rdata;
    nxt  = prev;
    if (!mis) begin
      if (wr) begin
        if (inr) model_mem[8'(addr >> 2)] = wdata;
      end else begin
        nxt = inr ? model_mem[8'(addr >> 2)] : 32'h0;
      end
    end
    model_rdata = nxt;

    @(negedge clk);
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    check("busy_at_accept", 32'(busy), 32'd1);
    check("ready_at_accept", 32'(resp_ready), 32'd0);
    if (hold) begin
      req_read  = 1'b0;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = $urandom;
    end else begin
      req_read  = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
    for (int k = 1; k <= WS + 2; k++) begin
      @(posedge clk); #1;
      check("ready", 32'(resp_ready), 32'(k == WS + 1));
      check("busy", 32'(busy), 32'(k <= WS + 1));
      check("rdata", resp_rdata, (k >= WS + 1) ? nxt : prev);
      check("err", 32'(resp_err), 32'((k == WS + 1) && mis));
      if (k == WS + 1 && !hold) begin
        req_read  = 1'b0;
        req_write = 1'b0;
      end
    end
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    // Power-up reset with random requests present.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_read  = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(posedge clk); #1;
      check("rst_ready", 32'(resp_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
    end
    @(negedge clk);
    reset     = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_ready", 32'(resp_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < DEPTH; i++)
      txn(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // Write then read back.
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Request held through RESP must not reach 0x20 before IDLE.
    txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Out-of-range write and read, then word 0 untouched.
    txn(1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0);
    txn(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset one cycle after a store is accepted.
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_write = 1'b0;
    check("abort_busy_accept", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(resp_ready), 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    model_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_hold_ready", 32'(resp_ready), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // Misaligned read of word 1.
    txn(1'b1, 1'b0, 32'h6, 32'h0, 1'b0);

    // Simultaneous read and write behaves as a write.
    txn(1'b1, 1'b1, 32'hC, 32'h5A5A5A5A, 1'b0);
    txn(1'b1, 1'b0, 32'hC, 32'h0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      int          sel;
      int          op;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      op  = $urandom_range(0, 2);
      if (sel == 0)
        a = $urandom;
      else if (sel <= 2)
        a = 32'($urandom_range(0, DEPTH * 4 - 1));
      else
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      txn(op != 1, op != 0, a, $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
